// File: rtl/debounced_priority_encoder.sv
// debounced_priority_encoder: synchronise, debounce and priority-encode eight request lines onto a valid/ready handshake
module debounced_priority_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_in,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic       multi,
    output logic       busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      sync1_q, sync_q;
    logic [7:0]      snap_q, snap_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [2:0]      code_q, code_d, snap_code;
    logic            valid_q, valid_d, multi_q, multi_d, busy_q, busy_d, snap_multi;

    // ascending scan so the highest set line wins
    always_comb begin
        snap_code = 3'd0;
        for (int i = 0; i < 8; i++)
            if (snap_q[i]) snap_code = 3'(7 - i);
        snap_multi = (snap_q & (snap_q - 8'd1)) != 8'd0;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = multi_q;
        case (state_q)
            IDLE: if (sync_q != 8'd0) begin
                snap_d  = sync_q;
                cnt_d   = '0;
                state_d = DEBOUNCE;
            end
            DEBOUNCE: if (sync_q == 8'd0) state_d = IDLE;
            else if (sync_q != snap_q) begin
                snap_d = sync_q;
                cnt_d  = '0;
            end else if (cnt_q == LAST) begin
                code_d  = snap_code;
                multi_d = snap_multi;
                valid_d = 1'b1;
                state_d = HOLD;
            end else cnt_d = cnt_inc;
            HOLD: if (ready) begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: if (sync_q != 8'd0) cnt_d = '0;
            else if (cnt_q == LAST) state_d = IDLE;
            else cnt_d = cnt_inc;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 8'd0;
            sync_q  <= 8'd0;
            snap_q  <= 8'd0;
            cnt_q   <= '0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= req_in;
            sync_q  <= sync1_q;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            busy_q  <= busy_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign multi = multi_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_debounced_priority_encoder.sv
// tb_debounced_priority_encoder: directed checks of latency, encoding, handshake, bounce rejection and reset
module tb_debounced_priority_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = 8'd0;
    logic       ready = 1'b0;
    logic [2:0] code;
    logic       valid, multi, busy;
    int         checks = 0;
    int         errors = 0;
    int         n, nv, nbad;

    debounced_priority_encoder dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ready(ready),
        .code(code), .valid(valid), .multi(multi), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int max, output int e);
        e = 0;
        while (!valid && e < max) begin
            step(1);
            e++;
        end
    endtask

    task automatic count_valid(input int k, output int c);
        c = 0;
        repeat (k) begin
            step(1);
            if (valid) c++;
        end
    endtask

    task automatic press(input logic [7:0] v, input int lat, input int exp_code, input int exp_multi, input string tag);
        req_in = v;
        wait_valid(30, n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_code"}, code, exp_code);
        check({tag, "_multi"}, multi, exp_multi);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        check("rst_code", code, 0);
        check("rst_valid", valid, 0);
        check("rst_multi", multi, 0);
        check("rst_busy", busy, 0);

        ready = 1'b1;
        press(8'h80, 7, 0, 0, "p80");
        step(1);
        check("p80_drop", valid, 0);
        count_valid(20, nv);
        check("p80_held_novalid", nv, 0);
        check("p80_busy_held", busy, 1);
        req_in = 8'h00;
        step(8);
        check("p80_idle", busy, 0);

        ready = 1'b0;
        press(8'h05, 7, 5, 1, "p05");
        nbad = 0;
        repeat (20) begin
            step(1);
            if (!valid || code != 3'd5) nbad++;
        end
        check("p05_stable", nbad, 0);
        ready = 1'b1;
        step(1);
        check("p05_drop", valid, 0);
        req_in = 8'h00;
        step(8);

        req_in = 8'h10;
        step(2);
        req_in = 8'h00;
        step(1);
        check("bounce_novalid", valid, 0);
        press(8'h10, 7, 3, 0, "bounce");
        step(1);
        check("bounce_drop", valid, 0);
        req_in = 8'h00;
        step(8);
        req_in = 8'h02;
        step(1);
        req_in = 8'h00;
        count_valid(12, nv);
        check("pulse_novalid", nv, 0);
        check("pulse_idle", busy, 0);

        req_in = 8'h01;
        step(3);
        press(8'h40, 7, 1, 0, "chg");
        step(1);
        req_in = 8'h00;
        step(8);

        press(8'h20, 7, 2, 0, "p20");
        step(1);
        req_in = 8'h00;
        step(3);
        req_in = 8'h20;
        step(1);
        req_in = 8'h00;
        step(3);
        check("relglitch_busy", busy, 1);
        count_valid(6, nv);
        check("relglitch_novalid", nv, 0);
        check("relglitch_idle", busy, 0);
        press(8'h02, 7, 6, 0, "p02");
        step(1);
        req_in = 8'h00;
        step(8);

        ready = 1'b0;
        press(8'h08, 7, 4, 0, "p08");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_valid", valid, 0);
        check("mrst_code", code, 0);
        check("mrst_multi", multi, 0);
        check("mrst_busy", busy, 0);
        wait_valid(30, n);
        check("mrst_lat", n, 7);
        check("mrst_code2", code, 4);
        ready = 1'b1;
        step(1);
        req_in = 8'h00;
        step(8);

        press(8'hFF, 7, 0, 1, "pff");
        step(1);
        req_in = 8'h00;
        step(8);
        press(8'h01, 7, 7, 0, "p01");
        step(1);
        req_in = 8'h00;
        step(8);
        check("end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
